// File: rtl/crossbar_pkg.sv
// Shared crossbar widths, command encodings and the slave-port FSM state type.
package crossbar_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/slave_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin: a lone requester wins, a tie goes to the
// master that did not win last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/slave_port_arbiter.sv
// Slave-side crossbar port: arbitrates two masters onto one slave, issues a
// single-cycle request and routes the completion (or a timeout error) back.
module slave_port_arbiter
  import crossbar_pkg::*;
#(
  parameter logic SLAVE_ID = 1'b0,
  parameter int   TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_resp,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_resp,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_cmd,
  output logic [ADDR_W-2:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic              s_resp,
  input  logic [DATA_W-1:0] s_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t        state;
  logic              g;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        elig;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              timed_out;
  logic [1:0]        m_ack;
  logic [1:0]        m_resp;
  logic [1:0]        m_err;
  logic [DATA_W-1:0] m_rdata [2];

  assign elig[0]   = m0_req && (m0_addr[ADDR_W-1] == SLAVE_ID);
  assign elig[1]   = m1_req && (m1_addr[ADDR_W-1] == SLAVE_ID);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  rr_arb2 u_rr (
    .req       (elig),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      s_req      <= 1'b0;
      s_cmd      <= CMD_READ;
      s_addr     <= '0;
      s_wdata    <= '0;
      m_ack      <= '0;
      m_resp     <= '0;
      m_err      <= '0;
      m_rdata[0] <= '0;
      m_rdata[1] <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          g       <= gnt_idx;
          s_req   <= 1'b1;
          s_cmd   <= gnt_idx ? m1_cmd : m0_cmd;
          s_addr  <= gnt_idx ? m1_addr[ADDR_W-2:0] : m0_addr[ADDR_W-2:0];
          s_wdata <= gnt_idx ? m1_wdata : m0_wdata;
          state   <= ISSUE;
        end
        ISSUE: begin
          s_req <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        // A real ack takes priority over a timeout landing in the same cycle.
        WAIT: if (s_ack || timed_out) begin
          m_ack[g]   <= 1'b1;
          m_resp[g]  <= s_ack & s_resp;
          m_err[g]   <= ~s_ack;
          m_rdata[g] <= s_ack ? s_rdata : '0;
          last_grant <= g;
          state      <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Guard cycle: the winner drops its req here, so requests are not sampled.
        DONE: begin
          m_ack  <= '0;
          m_resp <= '0;
          m_err  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_ack   = m_ack[0];
  assign m0_resp  = m_resp[0];
  assign m0_err   = m_err[0];
  assign m0_rdata = m_rdata[0];
  assign m1_ack   = m_ack[1];
  assign m1_resp  = m_resp[1];
  assign m1_err   = m_err[1];
  assign m1_rdata = m_rdata[1];
endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter: transaction table plus hand-written
// contention, filtering, timeout/late-ack and mid-transaction reset sequences.
module tb_slave_port_arbiter;
  import crossbar_pkg::*;

  localparam logic SLAVE_ID = 1'b0;
  localparam int   TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_cmd = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_ack, m0_resp, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_cmd = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_ack, m1_resp, m1_err;
  logic [31:0] m1_rdata;
  logic        s_req, s_cmd;
  logic [30:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_ack = 1'b0, s_resp = 1'b0;
  logic [31:0] s_rdata = '0;

  logic        ack_en = 1'b1;
  logic        inject = 1'b0;
  logic [31:0] mem [16];

  int checks = 0;
  int failures = 0;

  slave_port_arbiter #(.SLAVE_ID(SLAVE_ID), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Slave model: registered one-cycle ack; inject forces an unsolicited ack.
  always @(posedge clk) begin
    s_ack   <= (s_req && ack_en) || inject;
    s_resp  <= inject ? 1'b1 : (s_req && !s_cmd);
    s_rdata <= inject ? 32'hBAD0_BAD0 :
               (s_req && !s_cmd) ? mem[s_addr[3:0]] : 32'h0;
    if (s_req && s_cmd) mem[s_addr[3:0]] <= s_wdata;
  end

  typedef struct {
    logic        mst;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{m0_ack, m0_resp, m0_err, m0_rdata, m1_ack, m1_resp, m1_err, m1_rdata,
             s_req, s_cmd, s_addr, s_wdata};
  endfunction

  task automatic set_m(input logic mst, input logic req, input logic cmd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (mst) begin
      m1_req = req; m1_cmd = cmd; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_cmd = cmd; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // Raise the request at a negedge, watch up to 20 cycles, check every field.
  task automatic run_vec(input vec_t v, input string tag);
    int          c_sreq = -1;
    int          c_ack = -1;
    int          n_sreq = 0;
    logic        other = 1'b0;
    logic [30:0] sa = '0;
    logic        sc = 1'b0;
    logic [31:0] sw = '0;
    logic        r = 1'b0, e = 1'b0, still = 1'b0;
    logic [31:0] rd = '0;
    set_m(v.mst, 1'b1, v.cmd, v.addr, v.wdata);
    for (int i = 1; i <= 20 && c_ack < 0; i++) begin
      @(negedge clk);
      if (s_req) begin
        n_sreq++;
        if (c_sreq < 0) begin
          c_sreq = i; sa = s_addr; sc = s_cmd; sw = s_wdata;
        end
      end
      if (v.mst ? m0_ack : m1_ack) other = 1'b1;
      if (v.mst ? m1_ack : m0_ack) begin
        c_ack = i;
        r  = v.mst ? m1_resp  : m0_resp;
        e  = v.mst ? m1_err   : m0_err;
        rd = v.mst ? m1_rdata : m0_rdata;
      end
    end
    if (v.mst) m1_req = 1'b0; else m0_req = 1'b0;
    @(negedge clk);
    still = v.mst ? m1_ack : m0_ack;
    if (v.mst ? m0_ack : m1_ack) other = 1'b1;
    chk({tag, "_sreq_cycle"}, c_sreq, 1);
    chk({tag, "_sreq_count"}, n_sreq, 1);
    chk({tag, "_s_addr"}, {1'b0, sa}, {1'b0, v.addr[30:0]});
    chk({tag, "_s_cmd"}, sc, v.cmd);
    chk({tag, "_s_wdata"}, sw, v.wdata);
    chk({tag, "_ack_latency"}, c_ack, v.exp_lat);
    chk({tag, "_resp"}, r, v.exp_resp);
    chk({tag, "_err"}, e, v.exp_err);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_other_ack"}, other, 1'b0);
    chk({tag, "_ack_pulse"}, still, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_zero", any_out(), 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   ack_who [$];
    int   ack_cyc [$];
    logic both, rr0, rr1, seen;
    vec_t tv;

    vecs[0] = '{1'b0, CMD_WRITE, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 32'h0,         3, 1'b0};
    vecs[1] = '{1'b1, CMD_READ,  32'h0000_0005, 32'h0,         1'b1, 32'hDEAD_BEEF, 3, 1'b0};
    vecs[2] = '{1'b1, CMD_WRITE, 32'h0000_000A, 32'h1234_5678, 1'b0, 32'h0,         3, 1'b0};
    vecs[3] = '{1'b0, CMD_READ,  32'h0000_000A, 32'h0,         1'b1, 32'h1234_5678, 3, 1'b0};
    vecs[4] = '{1'b0, CMD_READ,  32'h7FFF_FFF5, 32'h0,         1'b1, 32'hDEAD_BEEF, 3, 1'b0};
    vecs[5] = '{1'b1, CMD_WRITE, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         3, 1'b0};
    vecs[6] = '{1'b1, CMD_READ,  32'h0000_0000, 32'h0,         1'b1, 32'hFFFF_FFFF, 3, 1'b0};

    #1;
    chk("initial_reset_outputs_zero", any_out(), 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Contention: both masters keep re-requesting; expect M0,M1,M0,M1 four apart.
    set_m(1'b0, 1'b1, CMD_READ, 32'h0000_0005, 32'h0);
    set_m(1'b1, 1'b1, CMD_READ, 32'h0000_000A, 32'h0);
    do_reset();
    both = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    for (int i = 1; i <= 40 && ack_who.size() < 4; i++) begin
      @(negedge clk);
      if (rr0) m0_req = 1'b1;
      if (rr1) m1_req = 1'b1;
      rr0 = 1'b0; rr1 = 1'b0;
      if (m0_ack && m1_ack) both = 1'b1;
      if (m0_ack) begin
        ack_who.push_back(0); ack_cyc.push_back(i);
        chk("cont_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 1'b0; rr0 = 1'b1;
      end
      if (m1_ack) begin
        ack_who.push_back(1); ack_cyc.push_back(i);
        chk("cont_m1_rdata", m1_rdata, 32'h1234_5678);
        m1_req = 1'b0; rr1 = 1'b1;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("cont_ack_count", ack_who.size(), 4);
    chk("cont_both_acks", both, 1'b0);
    for (int k = 0; k < ack_who.size(); k++) begin
      chk($sformatf("cont_grant%0d", k), ack_who[k], k % 2);
      if (k > 0) chk($sformatf("cont_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 4);
    end
    repeat (2) @(negedge clk);

    // Filtering: addr[31]=1 targets the other slave.
    set_m(1'b0, 1'b1, CMD_WRITE, 32'h8000_0003, 32'h5555_AAAA);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_req || m0_ack || m1_ack) seen = 1'b1;
    end
    m0_req = 1'b0;
    chk("filter_no_activity", seen, 1'b0);

    // Timeout: ISSUE is cycle 1, WAIT counts 0..TIMEOUT-1, ack on the cycle after.
    ack_en = 1'b0;
    tv = '{1'b0, CMD_READ, 32'h0000_0005, 32'h0, 1'b0, 32'h0, TIMEOUT + 2, 1'b1};
    run_vec(tv, "timeout");
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m0_ack || m1_ack || m0_resp || m1_resp || s_req) seen = 1'b1;
    end
    chk("late_ack_ignored", seen, 1'b0);
    chk("late_ack_m0_rdata", m0_rdata, 32'h0);

    // Reset during WAIT aborts M0; pending M1 is then served normally.
    set_m(1'b0, 1'b1, CMD_READ, 32'h0000_0005, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_req) seen = 1'b1;
    end
    chk("midrst_issue_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    set_m(1'b1, 1'b1, CMD_READ, 32'h0000_000A, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs_zero", any_out(), 1'b0);
    chk("midrst_s_addr", {1'b0, s_addr}, 32'h0);
    m0_req = 1'b0;
    @(negedge clk);
    ack_en = 1'b1;
    rst_n = 1'b1;
    tv = '{1'b1, CMD_READ, 32'h0000_000A, 32'h0, 1'b1, 32'h1234_5678, 3, 1'b0};
    run_vec(tv, "midrst_m1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
